// File: rtl/stage_if.sv
// Instruction-fetch stage: fetches each 32-bit instruction as four byte reads over a shared
// byte-wide memory port, assembles them little-endian and hands a registered {pc, inst, valid} to ID.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_req_o,
  output logic [31:0] mem_a_o,
  input  logic        stall_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [2:0]       issue_idx_q, issue_idx_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [3:0][7:0]  buf_q, buf_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             valid_q, valid_d;

  logic redirect;
  logic handoff;

  // Only the valid instruction sitting in ID may redirect, and a stall defers it.
  always_comb begin
    redirect  = branch_enable_i & valid_q & ~stall_i;
    handoff   = (cnt_q == 3'd4) & ~stall_i & ~redirect;
    mem_req_o = ~rst & rdy & mem_grant_i & (issue_idx_q < 3'd4) & ~redirect & ~handoff;
    mem_a_o   = rst ? 32'h0 : fetch_pc_q + 32'(issue_idx_q);
  end

  // NOTE: every next-state variable gets a default first so this block can never infer a latch.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issue_idx_d = issue_idx_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    buf_d       = buf_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;

    if (rdy) begin
      pending_d = mem_req_o;
      if (mem_req_o) issue_idx_d = issue_idx_q + 3'd1;
      // A pending byte always lands while cnt < 4, so the low two bits index the buffer.
      if (pending_q) begin
        buf_d[cnt_q[1:0]] = mem_din_i;
        cnt_d             = cnt_q + 3'd1;
      end

      if (redirect) begin
        fetch_pc_d  = branch_addr_i & 32'hFFFF_FFFC;
        issue_idx_d = 3'd0;
        cnt_d       = 3'd0;
        pending_d   = 1'b0;
        inst_d      = 32'h0;
        valid_d     = 1'b0;
      end else if (!stall_i) begin
        if (handoff) begin
          pc_d        = fetch_pc_q;
          inst_d      = buf_q;
          valid_d     = 1'b1;
          fetch_pc_d  = fetch_pc_q + 32'd4;
          issue_idx_d = 3'd0;
          cnt_d       = 3'd0;
        end else begin
          inst_d  = 32'h0;
          valid_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      issue_idx_q <= 3'd0;
      cnt_q       <= 3'd0;
      pending_q   <= 1'b0;
      pc_q        <= 32'h0;
      inst_q      <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issue_idx_q <= issue_idx_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: the byte buffer has no reset; each slot is written before cnt reaches 4 and it is read.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios followed by randomized traffic, all checked
// against a fetch-sequence model (expected byte addresses, instruction words and output hold rules).
module tb_stage_if;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, rdy, grant, stall, br_en;
  logic [31:0] br_addr;
  logic [7:0]  din = 8'h0;
  logic        mem_req_o;
  logic [31:0] mem_a_o, pc_o, inst_o;
  logic        inst_valid_o;

  stage_if #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .mem_grant_i     (grant),
    .mem_din_i       (din),
    .mem_req_o       (mem_req_o),
    .mem_a_o         (mem_a_o),
    .stall_i         (stall),
    .branch_enable_i (br_en),
    .branch_addr_i   (br_addr),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Byte memory: explicit bytes where placed, otherwise a fixed hash of the address.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = a * 32'd2654435761;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  // Read data appears the cycle after a request and holds otherwise.
  always @(posedge clk) if (mem_req_o) din <= mb(mem_a_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model state: base address of the word being fetched, bytes issued so far, and expected outputs.
  logic [31:0] fbase;
  int          ik;
  logic [31:0] m_pc, m_inst;
  logic        m_valid;
  logic        s_req;
  logic [31:0] s_addr;

  task automatic hold_chk(input string tag);
    check({tag, "_valid"}, 32'(inst_valid_o), 32'(m_valid));
    check({tag, "_pc"}, pc_o, m_pc);
    check({tag, "_inst"}, inst_o, m_inst);
  endtask

  // One clock cycle with the currently driven inputs; checks the request and the registered result.
  task automatic tick();
    logic redir;
    #1;
    s_req  = mem_req_o;
    s_addr = mem_a_o;
    redir  = !rst && rdy && br_en && m_valid && !stall;
    if (rst) begin
      check("rst_req", 32'(s_req), 32'd0);
      check("rst_addr", s_addr, 32'd0);
    end else if (!rdy || !grant || redir) begin
      check("req_gate", 32'(s_req), 32'd0);
    end
    if (s_req && !rst) begin
      check("req_addr", s_addr, fbase + 32'(ik));
      check("req_idx", 32'(ik < 4), 32'd1);
      ik++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
      fbase = RESET_PC; ik = 0;
      hold_chk("rst_out");
    end else if (!rdy) begin
      hold_chk("frozen");
    end else if (redir) begin
      m_inst = 32'h0; m_valid = 1'b0;
      fbase = br_addr & 32'hFFFF_FFFC; ik = 0;
      hold_chk("redirect");
    end else if (stall) begin
      hold_chk("stall_hold");
    end else if (inst_valid_o) begin
      check("handoff_bytes", 32'(ik), 32'd4);
      m_pc = fbase; m_inst = word(fbase); m_valid = 1'b1;
      fbase = fbase + 32'd4; ik = 0;
      hold_chk("handoff");
    end else begin
      m_inst = 32'h0; m_valid = 1'b0;
      hold_chk("bubble");
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1; rdy = 1'b1; grant = 1'b1; stall = 1'b0; br_en = 1'b0; br_addr = 32'h0;
    fbase = RESET_PC; ik = 0; m_pc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
    s_req = 1'b0; s_addr = 32'h0;
    mem[32'h0] = 8'h13; mem[32'h1] = 8'h05; mem[32'h2] = 8'h10; mem[32'h3] = 8'h00;
    mem[32'h4] = 8'h93; mem[32'h5] = 8'h00; mem[32'h6] = 8'h00; mem[32'h7] = 8'h00;

    // Reset, then the first fetch with grant held from cycle 0.
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("s1_addr", s_addr, 32'(c));
      check("s1_req", 32'(s_req), 32'd1);
    end
    tick();
    check("s1_idle_req", 32'(s_req), 32'd0);
    tick();
    check("s1_valid", 32'(inst_valid_o), 32'd1);
    check("s1_inst", inst_o, 32'h0010_0513);
    check("s1_pc", pc_o, 32'h0);

    // Fetch at pc 4 with grant lost for three cycles after the first byte.
    tick();
    check("s2_addr0", s_addr, 32'h4);
    grant = 1'b0;
    repeat (3) begin
      tick();
      check("s2_no_req", 32'(s_req), 32'd0);
    end
    grant = 1'b1;
    for (int c = 5; c < 8; c++) begin
      tick();
      check("s2_resume_addr", s_addr, 32'(c));
    end
    tick();
    check("s2_not_yet", 32'(inst_valid_o), 32'd0);
    tick();
    check("s2_valid", 32'(inst_valid_o), 32'd1);
    check("s2_pc", pc_o, 32'h4);
    check("s2_inst", inst_o, 32'h0000_0093);

    // Stall for 8 cycles with inst @4 in ID; the next word buffers meanwhile.
    stall = 1'b1;
    repeat (8) begin
      tick();
      check("s4_held_pc", pc_o, 32'h4);
      check("s4_held_inst", inst_o, 32'h0000_0093);
    end
    stall = 1'b0;
    tick();
    check("s4_valid", 32'(inst_valid_o), 32'd1);
    check("s4_pc", pc_o, 32'h8);
    check("s4_inst", inst_o, word(32'h8));

    // Branch request under stall is deferred, then taken exactly once.
    stall = 1'b1; br_en = 1'b1; br_addr = 32'h0000_0102;
    repeat (3) begin
      tick();
      check("s5_deferred", 32'(inst_valid_o), 32'd1);
      check("s5_deferred_pc", pc_o, 32'h8);
    end
    stall = 1'b0;
    tick();
    check("s5_redirect_valid", 32'(inst_valid_o), 32'd0);
    check("s5_redirect_req", 32'(s_req), 32'd0);
    tick();
    check("s5_once_addr", s_addr, 32'h100);
    check("s5_once_req", 32'(s_req), 32'd1);
    br_en = 1'b0;
    repeat (4) tick();
    tick();
    check("s5_tgt_valid", 32'(inst_valid_o), 32'd1);
    check("s5_tgt_pc", pc_o, 32'h100);

    // Redirect while a byte is in flight: that byte must be dropped.
    stall = 1'b1;
    tick();
    check("s3_inflight_addr", s_addr, 32'h104);
    stall = 1'b0; br_en = 1'b1; br_addr = 32'h0000_0102;
    tick();
    check("s3_valid", 32'(inst_valid_o), 32'd0);
    br_en = 1'b0;
    tick();
    check("s3_next_addr", s_addr, 32'h100);
    repeat (4) tick();
    tick();
    check("s3_refetch_pc", pc_o, 32'h100);
    check("s3_refetch_inst", inst_o, word(32'h100));

    // Address wrap past 32'hFFFF_FFFC, then reset mid-fetch.
    br_en = 1'b1; br_addr = 32'hFFFF_FFFC;
    tick();
    br_en = 1'b0;
    tick();
    check("s6_top_addr", s_addr, 32'hFFFF_FFFC);
    repeat (4) tick();
    tick();
    check("s6_top_pc", pc_o, 32'hFFFF_FFFC);
    check("s6_top_inst", inst_o, word(32'hFFFF_FFFC));
    tick();
    check("s6_wrap_addr", s_addr, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("s6_rst_valid", 32'(inst_valid_o), 32'd0);
    rst = 1'b0;
    tick();
    check("s6_restart_addr", s_addr, RESET_PC);
    check("s6_restart_req", 32'(s_req), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      rdy     = ($urandom_range(0, 9) != 0);
      grant   = ($urandom_range(0, 9) < 7);
      stall   = ($urandom_range(0, 9) < 2);
      br_en   = ($urandom_range(0, 9) == 0);
      br_addr = $urandom;
      tick();
    end

    // Forward progress with full grant, bounded.
    rst = 1'b0; rdy = 1'b1; grant = 1'b1; stall = 1'b0; br_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= inst_valid_o;
    end
    check("progress", 32'(seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
